// File: rtl/i2c_cfg_sequencer.sv
// rtl/i2c_cfg_sequencer.sv - walks a config LUT per camera channel and issues I2C commands to a shared master
// Optional build macro CFG_RETRY_EN: re-issue a failing entry up to 3 times before aborting.
module i2c_cfg_sequencer #(
    parameter int unsigned           NUM_CH     = 2,
    parameter int unsigned           IDX_W      = 8,
    parameter int unsigned           ADDR_W     = 8,
    parameter int unsigned           DATA_W     = 16,
    parameter int unsigned           READ_CNT   = 2,
    parameter logic [ADDR_W-1:0]     DELAY_ADDR = 8'hFF,
    parameter int unsigned           DELAY_UNIT = 1000,
    parameter int unsigned           INIT_DELAY = 20'd1000000,
    parameter int unsigned           CW         = 20,
    localparam int unsigned          CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic [IDX_W-1:0]         lut_index,
    input  logic [ADDR_W+DATA_W-1:0] lut_data,
    input  logic [IDX_W-1:0]         lut_size,
    output logic [CH_W-1:0]          ch_idx,
    output logic                     i2c_req,
    output logic                     i2c_rnw,
    output logic [ADDR_W-1:0]        i2c_addr,
    output logic [DATA_W-1:0]        i2c_wdata,
    input  logic                     i2c_done,
    input  logic                     i2c_nack,
    input  logic [DATA_W-1:0]        i2c_rdata,
    output logic                     busy,
    output logic                     cfg_done,
    output logic                     cfg_err,
    output logic [CH_W-1:0]          err_ch,
    output logic [IDX_W-1:0]         err_index
);

    localparam int unsigned PW = DATA_W + 32;

    typedef enum logic [3:0] {
        IDLE, INIT_WAIT, FETCH, ISSUE, WAIT_RESP, DELAY, NEXT, DONE, ERR
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    lut_index_q, lut_index_d;
    logic [CH_W-1:0]     ch_idx_q, ch_idx_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0]   cmd_data_q, cmd_data_d;
    logic                rnw_q, rnw_d;
    logic                req_q, req_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [CH_W-1:0]     err_ch_q, err_ch_d;
    logic [IDX_W-1:0]    err_index_q, err_index_d;
`ifdef CFG_RETRY_EN
    logic [1:0]          retry_q, retry_d;
`endif

    logic [ADDR_W-1:0]   lut_addr;
    logic [DATA_W-1:0]   lut_reg;
    logic [PW-1:0]       delay_prod;
    logic [CW-1:0]       delay_sat;
    logic                resp_fail;
    logic                last_entry;
    logic                last_ch;

    assign lut_addr   = lut_data[ADDR_W+DATA_W-1:DATA_W];
    assign lut_reg    = lut_data[DATA_W-1:0];
    assign delay_prod = PW'(lut_reg) * PW'(DELAY_UNIT);
    // Long delays clamp to the counter range rather than wrapping to a short one.
    assign delay_sat  = (|delay_prod[PW-1:CW]) ? {CW{1'b1}} : delay_prod[CW-1:0];
    assign resp_fail  = i2c_nack || (rnw_q && (i2c_rdata != cmd_data_q));
    assign last_entry = (lut_index_q == lut_size - IDX_W'(1));
    assign last_ch    = (ch_idx_q == CH_W'(NUM_CH - 1));

    always_comb begin
        state_d     = state_q;
        lut_index_d = lut_index_q;
        ch_idx_d    = ch_idx_q;
        cnt_d       = cnt_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        rnw_d       = rnw_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        err_ch_d    = err_ch_q;
        err_index_d = err_index_q;
`ifdef CFG_RETRY_EN
        retry_d     = retry_q;
`endif

        case (state_q)
            IDLE, DONE, ERR: begin
                state_d = IDLE;
                if (start) begin
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    err_ch_d    = '0;
                    err_index_d = '0;
                    lut_index_d = '0;
                    ch_idx_d    = '0;
                    busy_d      = 1'b1;
                    cnt_d       = CW'(INIT_DELAY);
                    state_d     = INIT_WAIT;
                end
            end
            INIT_WAIT: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = (lut_size == '0) ? DONE : FETCH;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FETCH: begin
                cmd_addr_d = lut_addr;
                cmd_data_d = lut_reg;
`ifdef CFG_RETRY_EN
                retry_d    = '0;
`endif
                if (lut_addr == DELAY_ADDR) begin
                    cnt_d   = delay_sat;
                    state_d = DELAY;
                end else begin
                    rnw_d   = (lut_index_q < IDX_W'(READ_CNT));
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT_RESP;
            WAIT_RESP: begin
                if (i2c_done) begin
                    if (resp_fail) begin
`ifdef CFG_RETRY_EN
                        if (retry_q != 2'd3) begin
                            retry_d = retry_q + 2'd1;
                            state_d = ISSUE;
                        end else begin
                            state_d = ERR;
                        end
`else
                        state_d = ERR;
`endif
                    end else begin
                        state_d = NEXT;
                    end
                end
            end
            DELAY: begin
                // A zero count still spends exactly one cycle here.
                if (cnt_q <= CW'(1)) begin
                    state_d = NEXT;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            NEXT: begin
                if (last_entry) begin
                    lut_index_d = '0;
                    if (last_ch) begin
                        state_d = DONE;
                    end else begin
                        ch_idx_d = ch_idx_q + CH_W'(1);
                        state_d  = FETCH;
                    end
                end else begin
                    lut_index_d = lut_index_q + IDX_W'(1);
                    state_d     = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase

        // Request drops for at least one cycle after every done, so a retry is a fresh request.
        req_d = ((state_d == ISSUE) || (state_d == WAIT_RESP)) &&
                !((state_q == WAIT_RESP) && i2c_done);

        if (state_d == DONE) begin
            done_d = 1'b1;
            busy_d = 1'b0;
        end
        if (state_d == ERR) begin
            err_d       = 1'b1;
            err_ch_d    = ch_idx_q;
            err_index_d = lut_index_q;
            busy_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lut_index_q <= '0;
            ch_idx_q    <= '0;
            cnt_q       <= '0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            rnw_q       <= 1'b0;
            req_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_ch_q    <= '0;
            err_index_q <= '0;
`ifdef CFG_RETRY_EN
            retry_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            lut_index_q <= lut_index_d;
            ch_idx_q    <= ch_idx_d;
            cnt_q       <= cnt_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            rnw_q       <= rnw_d;
            req_q       <= req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_ch_q    <= err_ch_d;
            err_index_q <= err_index_d;
`ifdef CFG_RETRY_EN
            retry_q     <= retry_d;
`endif
        end
    end

    assign lut_index = lut_index_q;
    assign ch_idx    = ch_idx_q;
    assign i2c_req   = req_q;
    assign i2c_rnw   = rnw_q;
    assign i2c_addr  = cmd_addr_q;
    assign i2c_wdata = cmd_data_q;
    assign busy      = busy_q;
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;
    assign err_ch    = err_ch_q;
    assign err_index = err_index_q;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// tb/tb_i2c_cfg_sequencer.sv - directed bench for i2c_cfg_sequencer with an I2C master model
module tb_i2c_cfg_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  lut_index;
    logic [23:0] lut_data;
    logic [7:0]  lut_size;
    logic [0:0]  ch_idx;
    logic        i2c_req;
    logic        i2c_rnw;
    logic [7:0]  i2c_addr;
    logic [15:0] i2c_wdata;
    logic        i2c_done;
    logic        i2c_nack;
    logic [15:0] i2c_rdata;
    logic        busy;
    logic        cfg_done;
    logic        cfg_err;
    logic [0:0]  err_ch;
    logic [7:0]  err_index;

    int          n_vec = 0;
    int          n_err = 0;
    bit          use_dly = 1'b0;
    bit          bad_read = 1'b0;
    int          nack_left = 0;
    int          idx2_cycles = 0;
    int          mcnt = 0;
    logic        req_prev = 1'b0;
    logic [25:0] cmd_log[$];

    always #5 clk = ~clk;

    i2c_cfg_sequencer #(
        .NUM_CH(2), .IDX_W(8), .ADDR_W(8), .DATA_W(16), .READ_CNT(2),
        .DELAY_ADDR(8'hFF), .DELAY_UNIT(10), .INIT_DELAY(20'd10), .CW(20)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .lut_index(lut_index), .lut_data(lut_data), .lut_size(lut_size),
        .ch_idx(ch_idx),
        .i2c_req(i2c_req), .i2c_rnw(i2c_rnw), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata),
        .i2c_done(i2c_done), .i2c_nack(i2c_nack), .i2c_rdata(i2c_rdata),
        .busy(busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
        .err_ch(err_ch), .err_index(err_index)
    );

    function automatic logic [23:0] entry(input logic [7:0] idx, input bit dly);
        case (idx)
            8'd0:    entry = {8'hFE, 16'hBEEF};
            8'd1:    entry = {8'h00, 16'h1313};
            8'd2:    entry = dly ? {8'hFF, 16'h0003} : {8'h0C, 16'h0001};
            8'd3:    entry = {8'h0D, 16'h0330};
            default: entry = 24'h0;
        endcase
    endfunction

    function automatic logic [25:0] exp_cmd(input logic ch, input logic [7:0] idx, input bit dly);
        exp_cmd = {ch, (idx < 8'd2), entry(idx, dly)};
    endfunction

    always_comb lut_data = entry(lut_index, use_dly);

    // Master model: done (with optional nack / read data) 5 cycles after each rising req.
    always @(negedge clk) begin
        if (rst) begin
            mcnt     = 0;
            i2c_done = 1'b0;
            i2c_nack = 1'b0;
            req_prev = 1'b0;
        end else begin
            i2c_done = 1'b0;
            i2c_nack = 1'b0;
            if (i2c_req && !req_prev) begin
                mcnt = 5;
                cmd_log.push_back({ch_idx, i2c_rnw, i2c_addr, i2c_wdata});
            end else if (mcnt != 0) begin
                mcnt = mcnt - 1;
                if (mcnt == 0) begin
                    i2c_done  = 1'b1;
                    i2c_rdata = (bad_read && ch_idx == 1'b1 && i2c_addr == 8'h00) ? 16'h1314 : i2c_wdata;
                    if (nack_left > 0 && ch_idx == 1'b0 && i2c_addr == 8'h0D) begin
                        i2c_nack  = 1'b1;
                        nack_left = nack_left - 1;
                    end
                end
            end
            req_prev = i2c_req;
            if (busy && ch_idx == 1'b0 && lut_index == 8'd2) idx2_cycles = idx2_cycles + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (cfg_done || cfg_err) break;
        end
        check("run_finished", 32'(cfg_done | cfg_err), 32'd1);
    endtask

    task automatic check_stream(input string tag, input int n, input bit dly);
        int k;
        logic [25:0] got;
        k = 0;
        check({tag, "_count"}, 32'(cmd_log.size()), 32'(n));
        for (int ch = 0; ch < 2; ch++) begin
            for (int idx = 0; idx < 4; idx++) begin
                if (!(dly && idx == 2) && k < n) begin
                    got = (k < cmd_log.size()) ? cmd_log[k] : 26'h3FFFFFF;
                    check($sformatf("%s_cmd%0d", tag, k), 32'(got), 32'(exp_cmd(ch[0], 8'(idx), dly)));
                    k++;
                end
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        lut_size  = 8'd4;
        i2c_done  = 1'b0;
        i2c_nack  = 1'b0;
        i2c_rdata = 16'h0;
        #1;
        check("reset_outputs", {busy, cfg_done, cfg_err, i2c_req, i2c_rnw, ch_idx, err_ch, 2'b00,
                                lut_index, err_index, 8'h00}, 32'h0);
        check("reset_cmd", {i2c_addr, i2c_wdata, 8'h00}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Run 1: plain walk, with a stray start while busy.
        cmd_log.delete();
        pulse_start();
        check("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < 200 && cmd_log.size() == 0; i++) @(negedge clk);
        pulse_start();
        wait_end(500);
        check("run1_done", {cfg_done, cfg_err, busy}, {29'd0, 3'b100});
        check_stream("run1", 8, 1'b0);

        // Run 2: entry 2 is a 3-unit delay (30 cycles in DELAY, 32 with FETCH and NEXT).
        use_dly = 1'b1;
        cmd_log.delete();
        idx2_cycles = 0;
        pulse_start();
        wait_end(500);
        check("run2_done", {cfg_done, cfg_err}, 32'b10);
        check("run2_idx2_cycles", 32'(idx2_cycles), 32'd32);
        check_stream("run2", 6, 1'b1);
        use_dly = 1'b0;

        // Run 3: ch1 index 1 read mismatch.
        bad_read = 1'b1;
        cmd_log.delete();
        pulse_start();
        wait_end(500);
        check("run3_flags", {cfg_done, cfg_err, busy}, 32'b010);
        check("run3_err_ch", 32'(err_ch), 32'd1);
        check("run3_err_index", 32'(err_index), 32'd1);
        repeat (30) @(negedge clk);
        check("run3_no_more_req", {i2c_req, 7'd0, 24'(cmd_log.size())}, {8'h00, 24'd6});
        bad_read = 1'b0;

        // Run 4: two nacks on ch0 index 3.
        nack_left = 2;
        cmd_log.delete();
        pulse_start();
        wait_end(500);
`ifdef CFG_RETRY_EN
        check("run4_flags", {cfg_done, cfg_err}, 32'b10);
        check("run4_count", 32'(cmd_log.size()), 32'd10);
`else
        check("run4_flags", {cfg_done, cfg_err}, 32'b01);
        check("run4_err_ch", 32'(err_ch), 32'd0);
        check("run4_err_index", 32'(err_index), 32'd3);
        check("run4_count", 32'(cmd_log.size()), 32'd4);
`endif
        nack_left = 0;

        // Run 5: reset while a request is outstanding, then a clean rerun.
        cmd_log.delete();
        pulse_start();
        for (int i = 0; i < 200 && !i2c_req; i++) @(negedge clk);
        check("run5_req_seen", 32'(i2c_req), 32'd1);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_req_drop", 32'(i2c_req), 32'd0);
        check("rst_outputs", {busy, cfg_done, cfg_err, i2c_rnw, ch_idx, err_ch, 2'b00,
                              lut_index, err_index, 8'h00}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cmd_log.delete();
        pulse_start();
        wait_end(500);
        check("rerun_done", {cfg_done, cfg_err}, 32'b10);
        check_stream("rerun", 8, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
